// File: rtl/mon_exp_loader_pkg.sv
// Shared defaults, derived beat geometry and FSM state type for the exponentiator BRAM loader.
// Also imported by the mon_exp_top integration bench.
package mon_exp_loader_pkg;

  localparam int unsigned AbitsDefault = 8;
  localparam int unsigned DbitsDefault = 512;
  localparam int unsigned BbitsDefault = 32;

  localparam int unsigned BeatsDefault = DbitsDefault / BbitsDefault;

  // Counter width for a given number of beats per word; never narrower than one bit.
  function automatic int unsigned beat_cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned BeatCntWDefault = beat_cnt_width(BeatsDefault);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite,
    StFin
  } loader_state_e;

endpackage

// File: rtl/mon_exp_beat_packer.sv
// Packs BBits-wide beats into a DBits-wide word, beat 0 in the least significant slot.
// word_o already includes a beat accepted in the current cycle.
module mon_exp_beat_packer
  import mon_exp_loader_pkg::*;
#(
  parameter int unsigned DBits = DbitsDefault,
  parameter int unsigned BBits = BbitsDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             beat_en_i,
  input  logic [BBits-1:0] beat_i,
  output logic [DBits-1:0] word_o,
  output logic             last_o
);

  localparam int unsigned Beats = DBits / BBits;
  localparam int unsigned CntW  = beat_cnt_width(Beats);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DBits-1:0] word_q, word_d;

  assign last_o = (cnt_q == CntW'(Beats - 1));

  always_comb begin
    word_o = word_q;
    if (beat_en_i) begin
      word_o[cnt_q*BBits +: BBits] = beat_i;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (beat_en_i) begin
      cnt_d  = last_o ? '0 : cnt_q + 1'b1;
      word_d = word_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/mon_exp_loader.sv
// Streams host beats into consecutive BRAM port-2 words, then pulses start for mon_exp_top.
// A zero-word load completes immediately with done but no start.
module mon_exp_loader
  import mon_exp_loader_pkg::*;
#(
  parameter int unsigned ABITS = AbitsDefault,
  parameter int unsigned DBITS = DbitsDefault,
  parameter int unsigned BBITS = BbitsDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_go,
  input  logic [ABITS-1:0] load_base,
  input  logic [ABITS:0]   load_words,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BBITS-1:0] in_data,
  output logic [ABITS-1:0] wr_addr2,
  output logic [DBITS-1:0] wr_data2,
  output logic             wr_en2,
  output logic             busy,
  output logic             done,
  output logic             start
);

  loader_state_e    state_q, state_d;
  logic [ABITS-1:0] base_q, base_d;
  logic [ABITS:0]   count_q, count_d;
  logic [ABITS:0]   word_cnt_q, word_cnt_d;
  logic             start_en_q, start_en_d;
  logic             wr_en_q, wr_en_d;
  logic [ABITS-1:0] wr_addr_q, wr_addr_d;
  logic [DBITS-1:0] wr_data_q, wr_data_d;

  logic             beat_en;
  logic             pk_clr;
  logic             pk_last;
  logic [DBITS-1:0] pk_word;

  mon_exp_beat_packer #(
    .DBits(DBITS),
    .BBits(BBITS)
  ) u_packer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (pk_clr),
    .beat_en_i(beat_en),
    .beat_i   (in_data),
    .word_o   (pk_word),
    .last_o   (pk_last)
  );

  assign in_ready = (state_q == StFill);
  assign beat_en  = in_valid & in_ready;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);
  assign start    = done & start_en_q;
  assign wr_en2   = wr_en_q;
  assign wr_addr2 = wr_addr_q;
  assign wr_data2 = wr_data_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    start_en_d = start_en_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pk_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_go) begin
          base_d     = load_base;
          count_d    = load_words;
          word_cnt_d = '0;
          pk_clr     = 1'b1;
          start_en_d = (load_words != '0);
          state_d    = (load_words != '0) ? StFill : StFin;
        end
      end
      StFill: begin
        // Register the write on the edge that takes the final beat so wr_en2 lines up with WRITE.
        if (beat_en && pk_last) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + word_cnt_q[ABITS-1:0];
          wr_data_d = pk_word;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_d == count_q) begin
          state_d = StFin;
        end else begin
          pk_clr  = 1'b1;
          state_d = StFill;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      start_en_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      start_en_q <= start_en_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_mon_exp_loader.sv
// Scoreboard bench for mon_exp_loader: loads are modelled as beat lists split into words,
// expected writes and done/start events are queued at issue time and popped by a monitor.
module tb_mon_exp_loader;

  localparam int ABITS = 8;
  localparam int DBITS = 512;
  localparam int BBITS = 32;
  localparam int BEATS = DBITS / BBITS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_go;
  logic [ABITS-1:0] load_base;
  logic [ABITS:0]   load_words;
  logic             in_valid;
  logic             in_ready;
  logic [BBITS-1:0] in_data;
  logic [ABITS-1:0] wr_addr2;
  logic [DBITS-1:0] wr_data2;
  logic             wr_en2;
  logic             busy;
  logic             done;
  logic             start;

  mon_exp_loader #(
    .ABITS(ABITS),
    .DBITS(DBITS),
    .BBITS(BBITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_go   (load_go),
    .load_base (load_base),
    .load_words(load_words),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wr_addr2  (wr_addr2),
    .wr_data2  (wr_data2),
    .wr_en2    (wr_en2),
    .busy      (busy),
    .done      (done),
    .start     (start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ABITS-1:0] addr;
    logic [DBITS-1:0] data;
  } wr_t;

  wr_t  exp_wr[$];
  logic exp_ev[$];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int go_cyc = 0;
  int last_wr_cyc = 0;
  int last_done_cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int busy_cyc = 0;

  task automatic check(input string name, input logic [DBITS-1:0] act,
                       input logic [DBITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard whenever the DUT presents a write or a done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (in_ready) check("ready_only_in_fill", {busy, wr_en2, done}, 3'b100);
      if (wr_en2) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        check("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr2", wr_addr2, e.addr);
          check("wr_data2", wr_data2, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_expected", exp_ev.size() != 0, 1);
        if (exp_ev.size() != 0) check("start_with_done", start, exp_ev.pop_front());
      end else if (start) begin
        check("start_without_done", start, 0);
      end
    end
  end

  // Issue one load. abort_after >= 0 resets the DUT after that many beats are accepted.
  task automatic do_load(input logic [ABITS-1:0] base, input int n, input int valid_pct,
                         input bit incr, input bit spurious, input bit timing,
                         input int abort_after);
    logic [BBITS-1:0] beats[$];
    logic [DBITS-1:0] w;
    int got, guard, done0, wr0;
    bit v;
    for (int i = 0; i < n * BEATS; i++) beats.push_back(incr ? BBITS'(i) : BBITS'($urandom));
    for (int i = 0; i < n; i++) begin
      wr_t e;
      w = '0;
      for (int k = 0; k < BEATS; k++) w[k*BBITS +: BBITS] = beats[i*BEATS + k];
      e.addr = ABITS'(int'(base) + i);
      e.data = w;
      exp_wr.push_back(e);
    end
    exp_ev.push_back(n != 0);
    done0 = done_cnt;
    wr0   = wr_cnt;
    busy_cyc = 0;
    @(negedge clk);
    load_go    = 1'b1;
    load_base  = base;
    load_words = (ABITS+1)'(n);
    go_cyc     = cyc;
    @(negedge clk);
    load_go    = 1'b0;
    load_base  = ABITS'($urandom);
    load_words = (ABITS+1)'($urandom);
    got = 0;
    guard = 0;
    while (got < n * BEATS && guard < 5000) begin
      v = ($urandom_range(99) < valid_pct);
      in_valid = v;
      in_data  = v ? beats[got] : BBITS'($urandom);
      if (spurious && $urandom_range(3) == 0) begin
        load_go    = 1'b1;
        load_base  = 8'h40;
        load_words = (ABITS+1)'($urandom_range(1, 5));
      end else begin
        load_go = 1'b0;
      end
      if (v && in_ready) got++;
      @(negedge clk);
      guard++;
      if (abort_after >= 0 && got == abort_after) break;
    end
    load_go = 1'b0;
    if (abort_after >= 0) begin
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort_ctrl_reset", {in_ready, wr_en2, busy, done, start}, 5'b0);
      check("abort_addr_reset", wr_addr2, 0);
      check("abort_data_reset", wr_data2, 0);
      check("abort_no_write", wr_cnt - wr0, 0);
      exp_wr.delete();
      exp_ev.delete();
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    check("beats_consumed", got, n * BEATS);
    in_valid = 1'b1;
    in_data  = BBITS'($urandom);
    guard = 0;
    while (done_cnt == done0 && guard < 100) begin
      @(negedge clk);
      in_data = BBITS'($urandom);
      guard++;
    end
    in_valid = 1'b0;
    check("done_seen", done_cnt - done0, 1);
    check("write_count", wr_cnt - wr0, n);
    if (timing) begin
      if (n != 0) check("write_latency", last_wr_cyc - go_cyc, (BEATS + 1) * n);
      check("done_latency", last_done_cyc - go_cyc, (BEATS + 1) * n + 1);
      check("busy_cycles", busy_cyc, (BEATS + 1) * n + 1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_go    = 1'b0;
    load_base  = '0;
    load_words = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {in_ready, wr_en2, busy, done, start}, 5'b0);
    check("reset_addr", wr_addr2, 0);
    check("reset_data", wr_data2, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(8'h03, 1, 100, 1'b1, 1'b0, 1'b1, -1);  // single word, beats = index
    do_load(8'h03, 1, 50, 1'b1, 1'b0, 1'b0, -1);   // stalled beats
    do_load(8'hFE, 3, 100, 1'b0, 1'b0, 1'b1, -1);  // address wrap
    do_load(8'h20, 0, 100, 1'b0, 1'b0, 1'b1, -1);  // zero-word load
    do_load(8'h55, 1, 100, 1'b0, 1'b0, 1'b0, 7);   // reset after 7 beats
    do_load(8'h55, 1, 100, 1'b0, 1'b0, 1'b1, -1);  // fresh load after reset
    do_load(8'h10, 2, 70, 1'b0, 1'b1, 1'b0, -1);   // ignored load_go mid-load
    for (int i = 0; i < 12; i++) begin
      do_load(ABITS'($urandom), $urandom_range(0, 4), $urandom_range(30, 100), 1'b0,
              1'($urandom), 1'b0, -1);
    end
    repeat (3) @(negedge clk);
    check("writes_drained", exp_wr.size(), 0);
    check("events_drained", exp_ev.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
